local_history_predictor: RTL

Parametrised two-level local-history branch predictor for the instruction fetcher. It keeps a per-PC branch history table (BHT) and a pattern history table (PHT) of saturating counters, both sized by parameter. Prediction responses are registered; feedback updates are applied synchronously. Prediction and misprediction performance counters are exposed. It replaces the single-configuration combinational predictor in the Issue stage.

---
 rtl/local_history_predictor_if.sv | 29 ++
 rtl/local_history_predictor.sv | 89 ++++++++
 2 files changed

// File: rtl/local_history_predictor_if.sv
// Fetcher <-> local-history predictor bus: prediction request/response,
// resolved-branch feedback and performance counters.
interface local_history_predictor_if #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned PERF_WIDTH = 32
);
    logic                  IFPD_predict_en;
    logic [ADDR_WIDTH-1:0] IFPD_pc;
    logic                  IFPD_feedback_en;
    logic [ADDR_WIDTH-1:0] IFPD_feedback_pc;
    logic                  IFPD_branch_result;
    logic                  IFPD_predicted;
    logic                  PDIF_en;
    logic                  PDIF_predict_result;
    logic [PERF_WIDTH-1:0] PD_predict_cnt;
    logic [PERF_WIDTH-1:0] PD_mispredict_cnt;

    modport master (
        output IFPD_predict_en, IFPD_pc, IFPD_feedback_en, IFPD_feedback_pc,
               IFPD_branch_result, IFPD_predicted,
        input  PDIF_en, PDIF_predict_result, PD_predict_cnt, PD_mispredict_cnt
    );

    modport slave (
        input  IFPD_predict_en, IFPD_pc, IFPD_feedback_en, IFPD_feedback_pc,
               IFPD_branch_result, IFPD_predicted,
        output PDIF_en, PDIF_predict_result, PD_predict_cnt, PD_mispredict_cnt
    );
endinterface

// File: rtl/local_history_predictor.sv
// Two-level local-history branch predictor: per-PC history table selects a
// saturating counter in the pattern table; registered response, perf counters.
module local_history_predictor #(
    parameter int unsigned ADDR_WIDTH     = 32,
    parameter int unsigned HASH_WIDTH     = 4,
    parameter int unsigned HISTORY_LENGTH = 4,
    parameter int unsigned CNT_WIDTH      = 2,
    parameter int unsigned PERF_WIDTH     = 32
) (
    input  logic Sys_clk,
    input  logic Sys_rst,
    input  logic Sys_rdy,
    local_history_predictor_if.slave bus
);
    localparam int unsigned BHT_DEPTH = 2 ** HASH_WIDTH;
    localparam int unsigned PHT_AW    = HASH_WIDTH + HISTORY_LENGTH;
    localparam int unsigned PHT_DEPTH = 2 ** PHT_AW;
    localparam logic [CNT_WIDTH-1:0] CNT_INIT = CNT_WIDTH'((1 << (CNT_WIDTH - 1)) - 1);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX  = '1;

    logic [HISTORY_LENGTH-1:0] bht [BHT_DEPTH];
    logic [CNT_WIDTH-1:0]      pht [PHT_DEPTH];

    logic                  pdif_en_q;
    logic                  pdif_result_q;
    logic [PERF_WIDTH-1:0] predict_cnt_q;
    logic [PERF_WIDTH-1:0] mispredict_cnt_q;

    logic [HASH_WIDTH-1:0] pd_idx;
    logic [HASH_WIDTH-1:0] fb_idx;
    logic [PHT_AW-1:0]     pd_addr;
    logic [PHT_AW-1:0]     fb_addr;
    logic [CNT_WIDTH-1:0]  fb_cnt;
    logic [CNT_WIDTH-1:0]  fb_cnt_next;
    logic                  accept;
    logic                  unused_pc_bits;

    assign pd_idx  = bus.IFPD_pc[HASH_WIDTH+1:2];
    assign fb_idx  = bus.IFPD_feedback_pc[HASH_WIDTH+1:2];
    assign pd_addr = {pd_idx, bht[pd_idx]};
    assign fb_addr = {fb_idx, bht[fb_idx]};
    assign fb_cnt  = pht[fb_addr];
    assign accept  = Sys_rdy;

    assign unused_pc_bits = ^{bus.IFPD_pc[ADDR_WIDTH-1:HASH_WIDTH+2], bus.IFPD_pc[1:0],
                              bus.IFPD_feedback_pc[ADDR_WIDTH-1:HASH_WIDTH+2],
                              bus.IFPD_feedback_pc[1:0]};

    // Saturating counter step toward the resolved outcome.
    always_comb begin
        fb_cnt_next = fb_cnt;
        if (bus.IFPD_branch_result) begin
            if (fb_cnt != CNT_MAX) fb_cnt_next = fb_cnt + CNT_WIDTH'(1);
        end else begin
            if (fb_cnt != '0) fb_cnt_next = fb_cnt - CNT_WIDTH'(1);
        end
    end

    // Prediction reads the tables before this edge's feedback writes land.
    always_ff @(posedge Sys_clk) begin
        if (Sys_rst) begin
            for (int unsigned i = 0; i < BHT_DEPTH; i++) bht[i] <= '0;
            for (int unsigned j = 0; j < PHT_DEPTH; j++) pht[j] <= CNT_INIT;
            pdif_en_q        <= 1'b0;
            pdif_result_q    <= 1'b0;
            predict_cnt_q    <= '0;
            mispredict_cnt_q <= '0;
        end else if (!accept) begin
            pdif_en_q <= 1'b0;
        end else begin
            pdif_en_q <= bus.IFPD_predict_en;
            if (bus.IFPD_predict_en) begin
                pdif_result_q <= pht[pd_addr][CNT_WIDTH-1];
                predict_cnt_q <= predict_cnt_q + PERF_WIDTH'(1);
            end
            if (bus.IFPD_feedback_en) begin
                pht[fb_addr] <= fb_cnt_next;
                bht[fb_idx]  <= {bht[fb_idx][HISTORY_LENGTH-2:0], bus.IFPD_branch_result};
                if (bus.IFPD_branch_result != bus.IFPD_predicted)
                    mispredict_cnt_q <= mispredict_cnt_q + PERF_WIDTH'(1);
            end
        end
    end

    assign bus.PDIF_en             = pdif_en_q;
    assign bus.PDIF_predict_result = pdif_result_q;
    assign bus.PD_predict_cnt      = predict_cnt_q;
    assign bus.PD_mispredict_cnt   = mispredict_cnt_q;
endmodule
